cu_seq_fsm: RTL and testbench

Parametrised multi-cycle instruction sequencer. It is the next generation of the two-state fetch/decode control unit. It sits between the program ROM / PC counter and the accumulator datapath. It fetches a 1- or 2-word instruction over a valid-qualified ROM read, decodes it, and issues one-cycle control pulses to the PC and accumulator. Unlike its predecessor, it supports ROM wait states, immediate/address operands, conditional branching and a halt state.

---
 rtl/cu_pkg.sv | 25 ++
 rtl/cu_decode.sv | 50 +++++
 rtl/cu_seq_fsm.sv | 143 ++++++++++++++
 tb/tb_cu_seq_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared state, opcode and ALU types for the instruction sequencer.
// Optional feature macro used by cu_seq_fsm: CU_ILLEGAL_TRAP_EN.
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPERAND,
        EXEC,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1
    } alu_op_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_ADDI = 8'h02;
    localparam logic [7:0] OP_JMP  = 8'h03;
    localparam logic [7:0] OP_JZ   = 8'h04;
    localparam logic [7:0] OP_HLT  = 8'hFF;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode classifier for the sequencer.
// Only ir[7:0] carries the opcode; wider words ignore the upper bits.
module cu_decode
    import cu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] ir,
    output logic              two_word,
    output logic              is_halt,
    output logic              is_legal,
    output alu_op_t           alu_op,
    output logic              is_jump,
    output logic              is_cond
);

    logic [7:0] op;

    assign op = ir[7:0];

    // Classify the opcode into the control attributes the FSM needs.
    always_comb begin
        two_word = 1'b0;
        is_halt  = 1'b0;
        is_legal = 1'b1;
        alu_op   = ALU_PASS;
        is_jump  = 1'b0;
        is_cond  = 1'b0;
        unique case (1'b1)
            (op == OP_NOP): ;
            (op == OP_LDI): two_word = 1'b1;
            (op == OP_ADDI): begin
                two_word = 1'b1;
                alu_op   = ALU_ADD;
            end
            (op == OP_JMP): begin
                two_word = 1'b1;
                is_jump  = 1'b1;
            end
            (op == OP_JZ): begin
                two_word = 1'b1;
                is_jump  = 1'b1;
                is_cond  = 1'b1;
            end
            (op == OP_HLT): is_halt = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_seq_fsm.sv
// cu_seq_fsm: multi-cycle fetch/decode/operand/exec sequencer.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT.
module cu_seq_fsm
    import cu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_valid,
    input  logic              zero_flag,
    output logic              rom_req,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic [DATA_W-1:0] imm,
    output logic [1:0]        alu_op,
    output logic              acc_we,
    output logic              halted,
    output logic              illegal
);

    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("cu_seq_fsm: ADDR_W must not exceed DATA_W");
    end
    if (DATA_W < 8) begin : g_bad_data_w
        $error("cu_seq_fsm: DATA_W must hold an 8-bit opcode");
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              pc_inc_q, pc_inc_d;
    logic              pc_load_q, pc_load_d;
    logic              acc_we_q, acc_we_d;
    alu_op_t           alu_op_q, alu_op_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;

    logic    two_word, is_halt, is_legal, is_jump, is_cond;
    alu_op_t dec_alu;

    cu_decode #(
        .DATA_W(DATA_W)
    ) u_decode (
        .ir       (ir_q),
        .two_word (two_word),
        .is_halt  (is_halt),
        .is_legal (is_legal),
        .alu_op   (dec_alu),
        .is_jump  (is_jump),
        .is_cond  (is_cond)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        pc_inc_d  = 1'b0;
        pc_load_d = 1'b0;
        acc_we_d  = 1'b0;
        alu_op_d  = ALU_PASS;
        illegal_d = illegal_q;
        unique case (state_q)
            FETCH: begin
                if (rom_valid) begin
                    ir_d     = rom_data;
                    pc_inc_d = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (is_halt) begin
                    state_d = HALT;
                end else if (two_word) begin
                    state_d = OPERAND;
                end else if (is_legal) begin
                    state_d = FETCH;
                end else begin
`ifdef CU_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = HALT;
`else
                    state_d   = FETCH;
`endif
                end
            end
            OPERAND: begin
                if (rom_valid) begin
                    imm_d     = rom_data;
                    acc_we_d  = !is_jump;
                    alu_op_d  = dec_alu;
                    pc_load_d = is_jump && (!is_cond || zero_flag);
                    pc_inc_d  = !pc_load_d;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = FETCH;
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
        halted_d = (state_d == HALT);
    end

    // State and registered outputs; reset aborts any instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            imm_q     <= '0;
            pc_inc_q  <= 1'b0;
            pc_load_q <= 1'b0;
            acc_we_q  <= 1'b0;
            alu_op_q  <= ALU_PASS;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            pc_inc_q  <= pc_inc_d;
            pc_load_q <= pc_load_d;
            acc_we_q  <= acc_we_d;
            alu_op_q  <= alu_op_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign rom_req   = (state_q == FETCH) || (state_q == OPERAND);
    assign pc_inc    = pc_inc_q;
    assign pc_load   = pc_load_q;
    assign pc_target = imm_q[ADDR_W-1:0];
    assign imm       = imm_q;
    assign alu_op    = alu_op_q;
    assign acc_we    = acc_we_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_cu_seq_fsm.sv
// tb_cu_seq_fsm: randomized instruction streams against a per-instruction
// timeline model of the sequencer's control pulses.
module tb_cu_seq_fsm;
    import cu_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] rom_data = '0;
    logic              rom_valid = 1'b0;
    logic              zero_flag = 1'b0;
    logic              rom_req, pc_inc, pc_load, acc_we, halted, illegal;
    logic [ADDR_W-1:0] pc_target;
    logic [DATA_W-1:0] imm;
    logic [1:0]        alu_op;

    int n_tests = 0;
    int n_fail  = 0;

    bit        exp_halt = 1'b0;
    bit        exp_ill  = 1'b0;
    bit [7:0]  exp_imm  = 8'h00;

    cu_seq_fsm #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_data  (rom_data),
        .rom_valid (rom_valid),
        .zero_flag (zero_flag),
        .rom_req   (rom_req),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .imm       (imm),
        .alu_op    (alu_op),
        .acc_we    (acc_we),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string ph, input bit req, input bit inc,
                              input bit load, input bit we, input bit [1:0] alu);
        check({ph, ".rom_req"}, rom_req, req);
        check({ph, ".pc_inc"}, pc_inc, inc);
        check({ph, ".pc_load"}, pc_load, load);
        check({ph, ".acc_we"}, acc_we, we);
        check({ph, ".alu_op"}, alu_op, alu);
        check({ph, ".halted"}, halted, exp_halt);
        check({ph, ".illegal"}, illegal, exp_ill);
        check({ph, ".imm"}, imm, exp_imm);
        check({ph, ".pc_target"}, pc_target, exp_imm);
    endtask

    // One clock cycle: drive ROM inputs, check outputs at the falling edge.
    task automatic step(input string ph, input bit req, input bit inc,
                        input bit load, input bit we, input bit [1:0] alu,
                        input bit rv, input logic [7:0] rd);
        rom_valid = rv;
        rom_data  = rd;
        @(negedge clk);
        check_outs(ph, req, inc, load, we, alu);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rom_valid = 1'b0;
        #1;
        exp_halt = 1'b0;
        exp_ill  = 1'b0;
        exp_imm  = 8'h00;
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Timeline of one instruction from its first FETCH cycle.
    task automatic run_instr(input logic [7:0] op, input logic [7:0] opnd,
                             input int w0, input int w1, input bit zf);
        bit two, hlt, legal, load, we;
        bit [1:0] alu;
        two   = (op == OP_LDI) || (op == OP_ADDI) ||
                (op == OP_JMP) || (op == OP_JZ);
        hlt   = (op == OP_HLT);
        legal = two || hlt || (op == OP_NOP);
        zero_flag = zf;
        for (int i = 0; i < w0; i++)
            step("fetch_wait", 1, 0, 0, 0, 0, 0, 8'($urandom));
        step("fetch", 1, 0, 0, 0, 0, 1, op);
        step("decode", 0, 1, 0, 0, 0, 1'($urandom), 8'($urandom));
        if (hlt || (!legal && TRAP)) begin
            exp_halt = 1'b1;
            exp_ill  = !legal;
            return;
        end
        if (!two) return;
        for (int i = 0; i < w1; i++)
            step("opnd_wait", 1, 0, 0, 0, 0, 0, 8'($urandom));
        step("operand", 1, 0, 0, 0, 0, 1, opnd);
        load = (op == OP_JMP) || (op == OP_JZ && zf);
        we   = (op == OP_LDI) || (op == OP_ADDI);
        alu  = (op == OP_ADDI) ? 2'd1 : 2'd0;
        exp_imm = opnd;
        step("exec", 0, !load, load, we, alu, 1'($urandom), 8'($urandom));
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++)
            step("halt", 0, 0, 0, 0, 0, 1'($urandom), 8'($urandom));
    endtask

    initial begin
        logic [7:0] op;
        int r;
        #1;
        check_outs("por", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        apply_reset();

        run_instr(OP_NOP, 8'h00, 0, 0, 0);
        run_instr(OP_LDI, 8'h5A, 2, 2, 0);
        run_instr(OP_JZ, 8'h40, 0, 0, 1);
        run_instr(OP_JZ, 8'h40, 1, 0, 0);
        run_instr(OP_ADDI, 8'hC3, 0, 1, 1);
        run_instr(OP_JMP, 8'h17, 0, 0, 0);

        run_instr(8'h7E, 8'h00, 0, 0, 0);
        if (exp_halt) begin
            hold_halt(5);
            apply_reset();
        end
        run_instr(OP_NOP, 8'h00, 1, 0, 0);

        run_instr(OP_HLT, 8'h00, 0, 0, 0);
        hold_halt(20);
        apply_reset();

        // ADDI aborted by reset while waiting for its operand.
        run_instr(OP_LDI, 8'hA5, 0, 0, 0);
        zero_flag = 1'b0;
        step("ab_fetch", 1, 0, 0, 0, 0, 1, OP_ADDI);
        step("ab_decode", 0, 1, 0, 0, 0, 0, 8'h00);
        step("ab_wait", 1, 0, 0, 0, 0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        exp_imm = 8'h00;
        check_outs("ab_rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        rom_valid = 1'b1;
        rom_data  = 8'h33;
        @(posedge clk);
        #1;
        check_outs("ab_held", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rom_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            step("ab_after", 1, 0, 0, 0, 0, 0, 8'h00);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1:  op = OP_NOP;
                2, 3:  op = OP_LDI;
                4:     op = OP_ADDI;
                5:     op = OP_JMP;
                6, 7:  op = OP_JZ;
                8:     op = OP_ADDI;
                9:     op = OP_HLT;
                default: op = 8'($urandom_range(5, 254));
            endcase
            run_instr(op, 8'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom));
            if (exp_halt) begin
                hold_halt($urandom_range(1, 6));
                apply_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
